// File: rtl/result_decoder_if.sv
// Start/done handshake between the controller (master) and the result decoder (slave).
// The abort signal exists only when DECODER_ABORT_EN is defined.
interface result_decoder_if #(
  parameter int SIZE  = 4,
  parameter int RES_W = 24
);
  logic             start;
  logic [RES_W-1:0] result_in;
  logic             busy;
  logic             done;
  logic             found;
  logic [SIZE-1:0]  index;
`ifdef DECODER_ABORT_EN
  logic             abort;
`endif

  modport master (
`ifdef DECODER_ABORT_EN
    output abort,
`endif
    output start, result_in,
    input  busy, done, found, index
  );

  modport slave (
`ifdef DECODER_ABORT_EN
    input  abort,
`endif
    input  start, result_in,
    output busy, done, found, index
  );
endinterface

// File: rtl/result_decoder.sv
// Finds the smallest n with f(n)==V for f(0)=f(1)=1, f(n)=2f(n-1)+3f(n-2), one term per clock.
// Optional feature macro: DECODER_ABORT_EN (adds an abort input that cancels a search).
module result_decoder #(
  parameter int SIZE  = 4,
  parameter int MAX_N = 15,
  parameter int RES_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  result_decoder_if.slave  bus
);
  localparam int W = RES_W + 3;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t           state, state_nxt;
  logic [RES_W-1:0] tgt, cur, prev;
  logic [SIZE-1:0]  k;
  logic             found_q;
  logic [SIZE-1:0]  index_q;
  logic             match, exceed, limit, abort_hit;

  assign match  = (cur == tgt);
  assign exceed = (cur > tgt);
  assign limit  = (k == SIZE'(MAX_N));

`ifdef DECODER_ABORT_EN
  assign abort_hit = (state == SEARCH) && bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SEARCH;
      SEARCH:  if (abort_hit)                     state_nxt = IDLE;
               else if (match || exceed || limit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath; found/index only move on accepted start, search end, or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt     <= '0;
      cur     <= '0;
      prev    <= '0;
      k       <= '0;
      found_q <= 1'b0;
      index_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          tgt     <= bus.result_in;
          k       <= '0;
          cur     <= RES_W'(1);
          prev    <= RES_W'(1);
          found_q <= 1'b0;
          index_q <= '0;
        end
        SEARCH: begin
          if (abort_hit) begin
            found_q <= 1'b0;
            index_q <= '0;
          end else if (match) begin
            found_q <= 1'b1;
            index_q <= k;
          end else if (exceed || limit) begin
            found_q <= 1'b0;
            index_q <= '0;
          end else begin
            k    <= k + 1'b1;
            prev <= cur;
            // f(1) is seeded rather than computed; wide sum never exceeds f(MAX_N)
            if (k == '0) cur <= RES_W'(1);
            else cur <= RES_W'(({3'b0, cur} << 1) + ({3'b0, prev} << 1) + W'({3'b0, prev}));
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.found = found_q;
  assign bus.index = index_q;
endmodule

// File: tb/tb_result_decoder.sv
// Directed + randomized check of result_decoder against a table-lookup model of the sequence.
module tb_result_decoder;
  localparam int SIZE = 4, MAX_N = 15, RES_W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  longint tab [0:MAX_N];

  result_decoder_if #(.SIZE(SIZE), .RES_W(RES_W)) bus ();

  result_decoder #(.SIZE(SIZE), .MAX_N(MAX_N), .RES_W(RES_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome straight from the table: smallest matching n, else the first
  // term that overshoots (or the last index) decides when the search ends.
  task automatic model(input longint v, output logic f, output int idx, output int lat);
    int stop;
    f = 1'b0; idx = 0; stop = MAX_N;
    for (int n = 0; n <= MAX_N; n++)
      if (tab[n] == v) begin f = 1'b1; idx = n; stop = n; break; end
    if (!f)
      for (int n = 0; n <= MAX_N; n++)
        if (tab[n] > v) begin stop = n; break; end
    lat = stop + 2;
  endtask

  // Start a decode; optionally pulse start again (ignored) when latency count hits poke_at.
  task automatic decode(input string tag, input longint v, input int poke_at);
    logic ef; int ei, el, lat, ndone;
    model(v, ef, ei, el);
    @(negedge clk);
    bus.start = 1'b1; bus.result_in = RES_W'(v);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.result_in = RES_W'($urandom);
    check({tag, " found_clr"}, 32'(bus.found), 32'd0);
    lat = 1; ndone = 0;
    while (ndone == 0 && lat < 40) begin
      if (lat == poke_at) begin bus.start = 1'b1; bus.result_in = RES_W'($urandom); end
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
      if (bus.done) ndone = 1;
      else if (!bus.busy) begin lat = 99; break; end
    end
    check({tag, " done_seen"}, 32'(ndone), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(el));
    check({tag, " found"}, 32'(bus.found), 32'(ef));
    check({tag, " index"}, 32'(bus.index), 32'(ei));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    repeat (2) @(posedge clk); #1;
    check({tag, " held"}, {27'd0, bus.found, bus.index}, {27'd0, ef, 4'(ei)});
  endtask

  initial begin
    longint v;
    int sel, n;
    tab[0] = 1; tab[1] = 1;
    for (int i = 2; i <= MAX_N; i++) tab[i] = 2 * tab[i-1] + 3 * tab[i-2];
    bus.start = 1'b0; bus.result_in = '0;
`ifdef DECODER_ABORT_EN
    bus.abort = 1'b0;
`endif
    #2;
    check("reset_out", {28'd0, bus.busy, bus.done, bus.found, 1'b0} | 32'(bus.index), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("tab15", 32'(tab[15]), 32'd7174453);

    decode("v1",       1,       -1);
    decode("v365",     365,     -1);
    decode("vmax",     7174453, -1);
    decode("v100",     100,     -1);
    decode("vmax_p1",  7174454, -1);
    decode("v0",       0,       -1);
    decode("v3281_poke", 3281,  3);

    // async reset mid-search
    @(negedge clk);
    bus.start = 1'b1; bus.result_in = RES_W'(3281);
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("rst_mid", {29'd0, bus.busy, bus.done, bus.found} | 32'(bus.index), 32'd0);
    @(negedge clk); rst = 1'b0;
    decode("v13_after_rst", 13, -1);

`ifdef DECODER_ABORT_EN
    @(negedge clk);
    bus.start = 1'b1; bus.result_in = RES_W'(7174453);
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    check("abort_idle", {29'd0, bus.busy, bus.done, bus.found} | 32'(bus.index), 32'd0);
    n = 0;
    repeat (20) begin @(posedge clk); #1 if (bus.done) n++; end
    check("abort_no_done", 32'(n), 32'd0);
    decode("v41_after_abort", 41, -1);
`endif

    for (int r = 0; r < 24; r++) begin
      sel = int'($urandom_range(0, 3));
      n   = int'($urandom_range(0, MAX_N));
      case (sel)
        0: v = tab[n];
        1: v = tab[n] + 1;
        2: v = tab[n] - 1;
        default: v = longint'($urandom & 32'h00FF_FFFF);
      endcase
      decode($sformatf("rnd%0d", r), v, (r % 3 == 0) ? 2 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
